alu_pipe: RTL

// - Parametrised, 2-stage pipelined ALU with valid/ready handshake on input and output.
// - Supersedes the single-cycle ALU behind ALU_if: generic operand width, tagged transactions, flags.
// - Carries full backpressure and sustains one op/cycle.
// - Sits between the op issue logic and the result consumer; the class-based bench drives it through a new interface.

---
 rtl/alu_pipe_if.sv | 29 ++
 rtl/alu_pipe.sv | 122 ++++++++++++
 2 files changed

// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: an input op beat (valid/ready) and a result beat (valid/ready).
// The master modport is the op issuer and result consumer; the slave modport is the ALU.
interface alu_pipe_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_tag, out_flags
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with full valid/ready backpressure and a pass-through tag.
// Define ALU_SAT_EN to make ADD/SUB saturate on signed overflow instead of wrapping.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic             out_valid;
    logic [WIDTH-1:0] out_res;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;

    logic adv1;
    logic adv2;

    // A stage may advance when its successor is empty or is itself draining this cycle.
    assign adv2 = !out_valid || bus.out_ready;
    assign adv1 = !s1_valid || adv2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = out_valid;
    assign bus.out_res   = out_res;
    assign bus.out_tag   = out_tag;
    assign bus.out_flags = out_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= bus.in_valid;
        end
    end

    // NOTE: operand staging registers carry no reset; s1_valid alone says whether they hold a live op.
    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            s1_op  <= bus.in_op;
            s1_a   <= bus.in_a;
            s1_b   <= bus.in_b;
            s1_tag <= bus.in_tag;
        end
    end

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        sum   = {1'b0, s1_a} + {1'b0, s1_b};
        diff  = {1'b0, s1_a} - {1'b0, s1_b};
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (s1_op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (s1_a[MSB] == s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (s1_a[MSB] != s1_b[MSB]) && (res[MSB] != s1_a[MSB]);
            end
            OP_AND:  res = s1_a & s1_b;
            OP_OR:   res = s1_a | s1_b;
            OP_XOR:  res = s1_a ^ s1_b;
            OP_SHL:  res = s1_a << s1_b[SH_W-1:0];
            OP_SHR:  res = s1_a >> s1_b[SH_W-1:0];
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            default: res = '0;
        endcase
`ifdef ALU_SAT_EN
        // Overflow direction always follows the sign of a for both ADD and SUB.
        if (ovf) begin
            res = s1_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        res = res;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_res   <= res;
                out_tag   <= s1_tag;
                out_flags <= {carry, ovf, (res == '0), res[MSB]};
            end
        end
    end
endmodule
